// File: rtl/dense_pkg.sv
// Shared types and arithmetic helpers for the dense output layer.
// Build option: define DENSE_SAT_EN to saturate scores instead of wrapping them.
package dense_pkg;

  localparam int unsigned ACC_W   = 48;
  localparam int unsigned PROD_W  = 40;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned MAX_OUT = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    WRITE,
    DONE
  } state_t;

  // Reduce a 48-bit accumulator to a 32-bit score.
  function automatic logic [31:0] fit32(input logic signed [ACC_W-1:0] v);
`ifdef DENSE_SAT_EN
    if (v > 48'sh0000_7FFF_FFFF) begin
      return 32'h7FFF_FFFF;
    end else if (v < 48'shFFFF_8000_0000) begin
      return 32'h8000_0000;
    end else begin
      return 32'(v);
    end
`else
    return 32'(v);
`endif
  endfunction

endpackage

// File: rtl/dense_mac.sv
// Signed 32x8 multiply with 48-bit accumulate; load_bias restarts the sum from bias.
module dense_mac
  import dense_pkg::*;
(
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    load_bias,
  input  logic signed [31:0]      bias,
  input  logic signed [31:0]      a,
  input  logic signed [7:0]       b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  base;

  always_comb begin
    prod = PROD_W'(a) * PROD_W'(b);
    base = load_bias ? ACC_W'(bias) : acc;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      acc <= '0;
    end else begin
      acc <= base + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/dense_out_layer.sv
// Final fully-connected layer: streams activations/weights/biases from external
// memories and holds OUT_SIZE scores for a combinational read port.
// Build option: DENSE_SAT_EN selects saturating score conversion.
module dense_out_layer
  import dense_pkg::*;
#(
  parameter int unsigned IN_SIZE  = 64,
  parameter int unsigned OUT_SIZE = 10,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADDR_W-1:0]   in_addr,
  input  logic signed [31:0]  in_data,
  output logic [ADDR_W-1:0]   w_addr,
  input  logic signed [7:0]   w_data,
  output logic [ADDR_W-1:0]   b_addr,
  input  logic signed [31:0]  b_data,
  input  logic [15:0]         rd_addr,
  output logic [31:0]         rd_data,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(IN_SIZE - 1);
  localparam logic [IDX_W-1:0]  J_LAST = IDX_W'(OUT_SIZE - 1);

  state_t                   state, state_next;
  logic [IDX_W-1:0]         j;
  logic [ADDR_W-1:0]        k;
  logic [31:0]              scores [MAX_OUT];
  logic signed [ACC_W-1:0]  acc;
  logic                     mac_on;
  logic                     mac_first;
  logic signed [31:0]       mac_a;

  // Next-state and MAC control decode.
  always_comb begin
    state_next = state;
    mac_on     = 1'b0;
    mac_first  = 1'b0;
    mac_a      = '0;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = MAC;
      MAC: begin
        mac_on    = 1'b1;
        mac_first = (k == '0);
        mac_a     = in_data;
        if (k == K_LAST) state_next = WRITE;
      end
      WRITE:   state_next = (j == J_LAST) ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, counters, address generators and score file.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      j       <= '0;
      k       <= '0;
      in_addr <= '0;
      w_addr  <= '0;
      b_addr  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < int'(MAX_OUT); i++) scores[i] <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == LOAD) || (state_next == MAC) || (state_next == WRITE);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            j       <= '0;
            k       <= '0;
            in_addr <= '0;
            w_addr  <= '0;
            b_addr  <= '0;
          end
        end
        LOAD: begin
          k       <= '0;
          in_addr <= in_addr + ADDR_W'(1);
          w_addr  <= w_addr + ADDR_W'(1);
        end
        MAC: begin
          // Addresses already point one ahead; the last cycle leaves w_addr at the next row.
          if (k != K_LAST) begin
            k       <= k + ADDR_W'(1);
            in_addr <= in_addr + ADDR_W'(1);
            w_addr  <= w_addr + ADDR_W'(1);
          end
        end
        WRITE: begin
          scores[j] <= fit32(acc);
          if (j != J_LAST) begin
            j       <= j + IDX_W'(1);
            b_addr  <= ADDR_W'(j) + ADDR_W'(1);
            in_addr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Non-MAC cycles feed a zero activation so the accumulator holds.
  dense_mac u_mac (
    .clk       (clk),
    .clear     (rst),
    .load_bias (mac_first),
    .bias      (b_data),
    .a         (mac_a),
    .b         (w_data),
    .acc       (acc)
  );

  always_comb begin
    rd_data = '0;
    if (rd_addr < 16'(OUT_SIZE)) rd_data = scores[rd_addr[IDX_W-1:0]];
  end

  logic unused_mac_on;
  assign unused_mac_on = mac_on;

endmodule

// File: tb/tb_dense_out_layer.sv
// Self-checking bench for dense_out_layer: default-size and 4x2 instances
// checked against a plain-arithmetic reference model.
module tb_dense_out_layer;

  logic clk = 1'b0;
  logic rst;
  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-size instance (64 x 10)
  logic               d_start;
  logic [15:0]        d_in_addr, d_w_addr, d_b_addr, d_rd_addr;
  logic signed [31:0] d_in_data, d_b_data;
  logic signed [7:0]  d_w_data;
  logic [31:0]        d_rd_data;
  logic               d_busy, d_done;
  logic signed [31:0] d_act  [64];
  logic signed [7:0]  d_w    [640];
  logic signed [31:0] d_bias [10];
  logic [31:0]        d_exp  [16];
  logic               bt [1:800];
  logic               dt [1:800];

  // Small instance (4 x 2)
  logic               s_start;
  logic [15:0]        s_in_addr, s_w_addr, s_b_addr, s_rd_addr;
  logic signed [31:0] s_in_data, s_b_data;
  logic signed [7:0]  s_w_data;
  logic [31:0]        s_rd_data;
  logic               s_busy, s_done;
  logic signed [31:0] s_act  [4];
  logic signed [7:0]  s_w    [8];
  logic signed [31:0] s_bias [2];
  logic [31:0]        s_exp  [2];
  logic               sd [1:100];

  dense_out_layer u_dut (
    .clk(clk), .rst(rst), .start(d_start),
    .in_addr(d_in_addr), .in_data(d_in_data),
    .w_addr(d_w_addr), .w_data(d_w_data),
    .b_addr(d_b_addr), .b_data(d_b_data),
    .rd_addr(d_rd_addr), .rd_data(d_rd_data),
    .busy(d_busy), .done(d_done)
  );

  dense_out_layer #(.IN_SIZE(4), .OUT_SIZE(2), .ADDR_W(16)) u_small (
    .clk(clk), .rst(rst), .start(s_start),
    .in_addr(s_in_addr), .in_data(s_in_data),
    .w_addr(s_w_addr), .w_data(s_w_data),
    .b_addr(s_b_addr), .b_data(s_b_data),
    .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .busy(s_busy), .done(s_done)
  );

  // Registered memories; out-of-range addresses return junk that must never be used.
  always @(posedge clk) begin
    d_in_data <= (d_in_addr < 16'd64)  ? d_act[d_in_addr[5:0]]  : 32'sh5A5A_5A5A;
    d_w_data  <= (d_w_addr  < 16'd640) ? d_w[d_w_addr[9:0]]     : 8'sh55;
    d_b_data  <= (d_b_addr  < 16'd10)  ? d_bias[d_b_addr[3:0]]  : 32'sh3C3C_3C3C;
    s_in_data <= (s_in_addr < 16'd4)   ? s_act[s_in_addr[1:0]]  : 32'sh5A5A_5A5A;
    s_w_data  <= (s_w_addr  < 16'd8)   ? s_w[s_w_addr[2:0]]     : 8'sh55;
    s_b_data  <= (s_b_addr  < 16'd2)   ? s_bias[s_b_addr[0]]    : 32'sh3C3C_3C3C;
  end

  function automatic logic [31:0] fit(input longint v);
`ifdef DENSE_SAT_EN
    if (v > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (v < -64'sh8000_0000) return 32'h8000_0000;
`endif
    return 32'(v);
  endfunction

  function automatic void model_d();
    longint s;
    for (int j = 0; j < 16; j++) d_exp[j] = 32'h0;
    for (int j = 0; j < 10; j++) begin
      s = longint'(d_bias[j]);
      for (int k = 0; k < 64; k++) s += longint'(d_act[k]) * longint'(d_w[j*64+k]);
      d_exp[j] = fit(s);
    end
  endfunction

  function automatic void model_s();
    longint s;
    for (int j = 0; j < 2; j++) begin
      s = longint'(s_bias[j]);
      for (int k = 0; k < 4; k++) s += longint'(s_act[k]) * longint'(s_w[j*4+k]);
      s_exp[j] = fit(s);
    end
  endfunction

  // Pulses start, then records busy/done for cycles 1..ncyc (cycle 1 = LOAD of neuron 0).
  task automatic run_d(input int ncyc, input int p1, input int p2, input int rst_at);
    d_start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= ncyc; c++) begin
      bt[c] = d_busy;
      dt[c] = d_done;
      d_start = (c == p1) || (c == p2);
      if (c == rst_at) rst = 1'b1;
      if (c == rst_at + 1) rst = 1'b0;
      @(posedge clk); #1;
    end
    d_start = 1'b0;
  endtask

  task automatic run_s(input int ncyc);
    s_start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= ncyc; c++) begin
      sd[c] = s_done;
      s_start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_trace(input string name, input int ncyc);
    int bad_busy = 0;
    int first_done = -1;
    int n_done = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (bt[c] !== (c <= 660)) bad_busy++;
      if (dt[c] === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL %s_busy: %0d cycles off, required 0", name, bad_busy);
    end
    checks++;
    if (first_done != 661 || n_done != 1) begin
      errors++;
      $display("FAIL %s_done: first at %0d count %0d, required 661 count 1", name, first_done, n_done);
    end
  endtask

  task automatic read_d(input string name);
    for (int i = 0; i < 16; i++) begin
      d_rd_addr = 16'(i); #1;
      checks++;
      if (d_rd_data !== d_exp[i]) begin
        errors++;
        $display("FAIL %s_score[%0d]: got %08h required %08h", name, i, d_rd_data, d_exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({d_busy, d_done, s_busy, s_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000", {d_busy, d_done, s_busy, s_done});
    end
    checks++;
    if ({d_in_addr, d_w_addr, d_b_addr} !== 48'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h %h %h required 0", d_in_addr, d_w_addr, d_b_addr);
    end
    for (int i = 0; i < 16; i++) d_exp[i] = 32'h0;
    read_d("reset");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ones();
    for (int k = 0; k < 64; k++) d_act[k] = 32'sd1;
    for (int i = 0; i < 640; i++) d_w[i] = 8'sd1;
    for (int j = 0; j < 10; j++) d_bias[j] = 32'(j);
    run_d(665, 0, 0, 0);
    check_trace("ones", 665);
    for (int j = 0; j < 10; j++) begin
      d_rd_addr = 16'(j); #1;
      checks++;
      if (d_rd_data !== 32'(64 + j)) begin
        errors++;
        $display("FAIL ones_score[%0d]: got %0d required %0d", j, d_rd_data, 64 + j);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 64; k++) d_act[k] = $signed($urandom) >>> $urandom_range(0, 20);
    for (int i = 0; i < 640; i++) d_w[i] = 8'($urandom);
    for (int j = 0; j < 10; j++) d_bias[j] = $signed($urandom) >>> $urandom_range(0, 8);
    model_d();
    run_d(665, 0, 0, 0);
    check_trace("random", 665);
    read_d("random");
  endtask

  task automatic test_ignored_start();
    run_d(665, 5, 300, 0);
    check_trace("ignore", 665);
    read_d("ignore");
    d_rd_addr = 16'd10; #1;
    checks++;
    if (d_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL rd_10: got %08h required 0", d_rd_data);
    end
    d_rd_addr = 16'hFFFF; #1;
    checks++;
    if (d_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL rd_ffff: got %08h required 0", d_rd_data);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 64; k++) d_act[k] = $signed($urandom) >>> 10;
    for (int i = 0; i < 640; i++) d_w[i] = 8'($urandom);
    for (int j = 0; j < 10; j++) d_bias[j] = $signed($urandom) >>> 4;
    run_d(103, 0, 0, 100);
    checks++;
    if (bt[100] !== 1'b1 || bt[101] !== 1'b0 || dt[101] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flags: busy100=%b busy101=%b done101=%b required 1 0 0",
               bt[100], bt[101], dt[101]);
    end
    for (int i = 0; i < 16; i++) d_exp[i] = 32'h0;
    read_d("rstmid_clear");
    model_d();
    run_d(665, 0, 0, 0);
    check_trace("rstmid_rerun", 665);
    read_d("rstmid_rerun");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 64; k++) d_act[k] = $signed($urandom);
    model_d();
    run_d(661, 0, 0, 0);
    for (int k = 0; k < 64; k++) d_act[k] = $signed($urandom) >>> 16;
    model_d();
    run_d(665, 0, 0, 0);
    check_trace("b2b", 665);
    read_d("b2b");
  endtask

  task automatic test_small_vector();
    int first_done;
    s_act = '{-32'sd3, 32'sd5, -32'sd7, 32'sd2};
    s_w   = '{8'sd2, -8'sd1, 8'sd1, 8'sd4, -8'sd1, -8'sd1, -8'sd1, -8'sd1};
    s_bias = '{32'sd10, -32'sd10};
    run_s(15);
    first_done = -1;
    for (int c = 15; c >= 1; c--) if (sd[c] === 1'b1) first_done = c;
    checks++;
    if (first_done != 13) begin
      errors++;
      $display("FAIL small_done: got cycle %0d required 13", first_done);
    end
    s_rd_addr = 16'd0; #1;
    checks++;
    if (s_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL small_score0: got %0d required 0", $signed(s_rd_data));
    end
    s_rd_addr = 16'd1; #1;
    checks++;
    if (s_rd_data !== 32'hFFFF_FFF9) begin
      errors++;
      $display("FAIL small_score1: got %0d required -7", $signed(s_rd_data));
    end
    s_rd_addr = 16'd2; #1;
    checks++;
    if (s_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL small_rd2: got %08h required 0", s_rd_data);
    end
  endtask

  task automatic test_small_overflow();
    logic [31:0] req;
`ifdef DENSE_SAT_EN
    req = 32'h7FFF_FFFF;
`else
    req = 32'hFFFF_FE04;
`endif
    for (int k = 0; k < 4; k++) s_act[k] = 32'sh7FFF_FFFF;
    for (int i = 0; i < 8; i++) s_w[i] = 8'sd127;
    s_bias = '{32'sd0, 32'sd0};
    run_s(15);
    for (int j = 0; j < 2; j++) begin
      s_rd_addr = 16'(j); #1;
      checks++;
      if (s_rd_data !== req) begin
        errors++;
        $display("FAIL small_ovf[%0d]: got %08h required %08h", j, s_rd_data, req);
      end
    end
  endtask

  task automatic test_small_random();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) s_act[k] = $signed($urandom);
      for (int i = 0; i < 8; i++) s_w[i] = 8'($urandom);
      for (int j = 0; j < 2; j++) s_bias[j] = $signed($urandom);
      model_s();
      run_s(15);
      for (int j = 0; j < 2; j++) begin
        s_rd_addr = 16'(j); #1;
        checks++;
        if (s_rd_data !== s_exp[j]) begin
          errors++;
          $display("FAIL small_rand%0d[%0d]: got %08h required %08h", r, j, s_rd_data, s_exp[j]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    d_start = 1'b0;
    s_start = 1'b0;
    d_rd_addr = '0;
    s_rd_addr = '0;
    test_reset();
    test_ones();
    test_random();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_small_vector();
    test_small_overflow();
    test_small_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
